writeback_queue: RTL

Writeback stage feeding the register file's single write port. Accepts register results from two producers, the single-cycle ALU path and the multi-cycle memory/load path. Orders them in a small FIFO, oldest first, and drains exactly one write per clock into the register file. Upstream stages get back-pressure so that no result is ever lost when both producers complete in the same cycle.

---
 rtl/wb_pkg.sv | 36 +++
 rtl/wb_fifo.sv | 78 +++++++
 rtl/writeback_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_pkg
//  Purpose  : Shared definitions for the writeback queue: register-file
//             geometry, the queued entry type and the destination range check.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 4
`endif

package wb_pkg;

    localparam int WB_DATA_W = `REG_FILE_SIZE;
    localparam int WB_ADDR_W = `REG_FILE_ADDR_LEN;
    localparam int NUM_REGS  = 12;

    // One pending register-file write.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] val;
    } wb_entry_t;

    // True when dest names an architectural register (0..limit-1).
    function automatic logic is_valid_dest(input logic [WB_ADDR_W-1:0] dest,
                                           input int unsigned          limit);
        return (32'(dest) < limit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fifo
//  Purpose  : DEPTH-entry FIFO of wb_entry_t with two write ports and one
//             read port. The head is dequeued on every clock while non-empty.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             enq0_valid_i/   - first (older) enqueue slot
//             enq0_data_i
//             enq1_valid_i/   - second (younger) enqueue slot
//             enq1_data_i
//             head_o          - oldest entry, straight from storage flops
//             count_o         - current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq0_valid_i,
    input  wb_entry_t     enq0_data_i,
    input  logic          enq1_valid_i,
    input  wb_entry_t     enq1_data_i,
    output wb_entry_t     head_o,
    output logic [CW-1:0] count_o
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] w_wr1_ptr;
    logic [CW-1:0] count_q,  count_d;
    logic          w_deq;
    logic [1:0]    w_enq_n;

    always_comb begin
        w_deq     = (count_q != '0);
        w_enq_n   = {1'b0, enq0_valid_i} + {1'b0, enq1_valid_i};
        // Slot 1 lands directly behind slot 0 when both are written.
        w_wr1_ptr = wr_ptr_q + PW'(enq0_valid_i);
        wr_ptr_d  = wr_ptr_q + PW'(w_enq_n);
        rd_ptr_d  = rd_ptr_q + PW'(w_deq);
        count_d   = count_q + CW'(w_enq_n) - CW'(w_deq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; an empty queue exposes stale data
    // that the consumer ignores because the valid flag is low.
    always_ff @(posedge clk) begin
        if (enq0_valid_i) begin
            mem_q[wr_ptr_q] <= enq0_data_i;
        end
        if (enq1_valid_i) begin
            mem_q[w_wr1_ptr] <= enq1_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_queue
//  Purpose  : Merges ALU and load results into an ordered queue that drains
//             one write per clock into the register file's single write port.
//             Out-of-range destinations are dropped and flagged (sticky).
//  Ports    : clk, rst                      - clock, async active-high reset
//             alu_valid_i/alu_dest_i/alu_val_i - ALU result
//             mem_valid_i/mem_dest_i/mem_val_i - load result
//             in_ready_o                    - room for two entries this cycle
//             wr_en_o/wr_dest_o/wr_val_o    - register-file write port
//             count_o                       - queue occupancy
//             dest_err_o                    - sticky dropped-destination flag
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 4
`endif

module writeback_queue
    import wb_pkg::*;
#(
    parameter  int DATA_W   = `REG_FILE_SIZE,
    parameter  int ADDR_W   = `REG_FILE_ADDR_LEN,
    parameter  int NUM_REGS = wb_pkg::NUM_REGS,
    parameter  int DEPTH    = 4,   // power of two, >= 2
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_dest_i,
    input  logic [DATA_W-1:0] alu_val_i,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_dest_i,
    input  logic [DATA_W-1:0] mem_val_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_dest_o,
    output logic [DATA_W-1:0] wr_val_o,
    output logic [CW-1:0]     count_o,
    output logic              dest_err_o
);

    logic          w_ready;
    logic          w_mem_ok;
    logic          w_alu_ok;
    logic          w_mem_acc;
    logic          w_alu_acc;
    logic          w_drop;
    logic          w_enq0_valid;
    logic          w_enq1_valid;
    wb_entry_t     w_mem_entry;
    wb_entry_t     w_alu_entry;
    wb_entry_t     w_enq0_data;
    wb_entry_t     w_head;
    logic [CW-1:0] w_count;
    logic          dest_err_q, dest_err_d;

    // Ready is derived from registered occupancy only, so it never depends on
    // the same-cycle dequeue or on the producers' valid inputs.
    assign w_ready = (w_count <= CW'(DEPTH - 2));

    always_comb begin
        w_mem_entry.dest = mem_dest_i;
        w_mem_entry.val  = mem_val_i;
        w_alu_entry.dest = alu_dest_i;
        w_alu_entry.val  = alu_val_i;

        w_mem_ok  = is_valid_dest(mem_dest_i, NUM_REGS);
        w_alu_ok  = is_valid_dest(alu_dest_i, NUM_REGS);
        w_mem_acc = w_ready && mem_valid_i && w_mem_ok;
        w_alu_acc = w_ready && alu_valid_i && w_alu_ok;

        // Only results actually presented during a ready cycle can be dropped;
        // valid held high while stalled is not a new result.
        w_drop = w_ready && ((mem_valid_i && !w_mem_ok) ||
                             (alu_valid_i && !w_alu_ok));

        // Load result is the older instruction, so it takes slot 0; the ALU
        // result moves into slot 0 when the load is absent or dropped.
        w_enq0_valid = w_mem_acc || w_alu_acc;
        w_enq0_data  = w_mem_acc ? w_mem_entry : w_alu_entry;
        w_enq1_valid = w_mem_acc && w_alu_acc;

        dest_err_d = dest_err_q || w_drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_err_q <= 1'b0;
        end else begin
            dest_err_q <= dest_err_d;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .enq0_valid_i (w_enq0_valid),
        .enq0_data_i  (w_enq0_data),
        .enq1_valid_i (w_enq1_valid),
        .enq1_data_i  (w_alu_entry),
        .head_o       (w_head),
        .count_o      (w_count)
    );

    assign in_ready_o = w_ready;
    assign wr_en_o    = (w_count != '0);
    assign wr_dest_o  = w_head.dest;
    assign wr_val_o   = w_head.val;
    assign count_o    = w_count;
    assign dest_err_o = dest_err_q;

endmodule

`default_nettype wire
